// File: rtl/mem_copy_engine.sv
// Byte block copier for the 256x8 data memory: one granted read cycle, then one
// granted write cycle, per byte, sharing the memory port through a req/gnt pair.
module mem_copy_engine (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] src_addr,
   input  logic [7:0] dst_addr,
   input  logic [7:0] length,
   output logic       busy,
   output logic       done,
   output logic       mem_req,
   input  logic       mem_gnt,
   output logic [7:0] mem_addr,
   output logic       mem_write,
   output logic [7:0] mem_write_data,
   input  logic [7:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t     state;
   logic [7:0] src_ptr;
   logic [7:0] dst_ptr;
   logic [7:0] remaining;
   logic [7:0] buffer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         src_ptr   <= 8'd0;
         dst_ptr   <= 8'd0;
         remaining <= 8'd0;
         buffer    <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (length != 8'd0) begin
                     src_ptr   <= src_addr;
                     dst_ptr   <= dst_addr;
                     remaining <= length;
                     state     <= READ;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            READ: begin
               if (mem_gnt) begin
                  buffer <= mem_read_data;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               // The memory captures buffer at dst_ptr on this same edge.
               if (mem_gnt) begin
                  src_ptr   <= src_ptr + 8'd1;
                  dst_ptr   <= dst_ptr + 8'd1;
                  remaining <= remaining - 8'd1;
                  state     <= (remaining == 8'd1) ? DONE : READ;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy           = (state == READ) || (state == WRITE);
   assign mem_req        = busy;
   assign done           = (state == DONE);
   assign mem_write      = (state == WRITE) && mem_gnt;
   assign mem_write_data = buffer;

   always_comb begin
      mem_addr = 8'd0;
      case (state)
         READ:    mem_addr = src_ptr;
         WRITE:   mem_addr = dst_ptr;
         default: mem_addr = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a 256x8 memory model, table-driven copies and
// hand-written stall, start-while-busy and reset-mid-copy sequences.
module tb_mem_copy_engine;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] src_addr;
   logic [7:0] dst_addr;
   logic [7:0] length;
   logic       busy;
   logic       done;
   logic       mem_req;
   logic       mem_gnt;
   logic [7:0] mem_addr;
   logic       mem_write;
   logic [7:0] mem_write_data;
   logic [7:0] mem_read_data;

   mem_copy_engine dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .length         (length),
      .busy           (busy),
      .done           (done),
      .mem_req        (mem_req),
      .mem_gnt        (mem_gnt),
      .mem_addr       (mem_addr),
      .mem_write      (mem_write),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model plus a bench-side load port used only while the DUT is idle.
   logic [7:0] mem [0:255];
   logic       tb_we;
   logic [7:0] tb_addr;
   logic [7:0] tb_data;

   assign mem_read_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_write)  mem[mem_addr] <= mem_write_data;
      else if (tb_we) mem[tb_addr]  <= tb_data;
   end

   // Edge monitor: counts done/write/request cycles and logs granted read addresses.
   logic [7:0] rd_log [0:255];
   int rd_total = 0, wr_total = 0, done_total = 0, req_total = 0;

   always @(posedge clk) begin
      if (done)      done_total <= done_total + 1;
      if (mem_write) wr_total   <= wr_total + 1;
      if (mem_req)   req_total  <= req_total + 1;
      if (mem_req && mem_gnt && !mem_write) begin
         rd_log[rd_total[7:0]] <= mem_addr;
         rd_total              <= rd_total + 1;
      end
   end

   int n_checks = 0;
   int n_err    = 0;
   int rd_base, wr_base, done_base, req_base;
   bit stall [0:63];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      tb_addr = a;
      tb_data = d;
      tb_we   = 1'b1;
      tick();
      tb_we   = 1'b0;
   endtask

   function automatic logic [31:0] peek4(input logic [7:0] a);
      logic [7:0] p;
      logic [31:0] r;
      p = a;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         r = {r[23:0], mem[p]};
         p = p + 8'd1;
      end
      return r;
   endfunction

   // Issue one start and run until the done cycle, then step back into IDLE.
   // inj>0 raises a second, different start in cycles inj and inj+1.
   task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input int inj, output int cyc);
      src_addr  = s;
      dst_addr  = d;
      length    = l;
      start     = 1'b1;
      mem_gnt   = 1'b1;
      rd_base   = rd_total;
      wr_base   = wr_total;
      done_base = done_total;
      req_base  = req_total;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (cyc <= 60) begin
         mem_gnt = !stall[cyc];
         start   = (inj != 0) && (cyc >= inj) && (cyc < inj + 2);
         if (start) begin
            src_addr = 8'h20;
            dst_addr = 8'hC0;
            length   = 8'd5;
         end
         #1;
         if (!mem_gnt) chk($sformatf("stall_nowrite_c%0d", cyc), {31'd0, mem_write}, 32'd0);
         if (done) begin
            chk("busy_low_in_done", {31'd0, busy}, 32'd0);
            break;
         end
         tick();
         cyc++;
      end
      start   = 1'b0;
      mem_gnt = 1'b1;
      if (cyc > 60) begin
         n_checks++;
         n_err++;
         $display("FAIL done_timeout: got no done within 60 cycles, expected done");
      end
      tick();
   endtask

   typedef struct {
      logic [7:0]  src;
      logic [7:0]  dst;
      logic [7:0]  len;
      int          exp_cyc;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [4];
   int   cyc;

   initial begin
      vecs[0] = '{8'h10, 8'h80, 8'd4, 9, 32'hA1B2C3D4};
      vecs[1] = '{8'h10, 8'h90, 8'd0, 1, 32'h00000000};
      vecs[2] = '{8'hFE, 8'h40, 8'd4, 9, 32'h5A6B7C8D};
      vecs[3] = '{8'h12, 8'h20, 8'd1, 3, 32'hC3000000};
      for (int k = 0; k < 64; k++) stall[k] = 1'b0;

      rst = 1'b1; start = 1'b0; mem_gnt = 1'b0;
      src_addr = 8'h0; dst_addr = 8'h0; length = 8'h0;
      tb_we = 1'b0; tb_addr = 8'h0; tb_data = 8'h0;
      #2;
      chk("reset_outputs", {12'd0, busy, done, mem_req, mem_write, mem_addr, mem_write_data}, 32'd0);
      for (int k = 0; k < 256; k++) load(k[7:0], 8'h00);
      load(8'h10, 8'hA1); load(8'h11, 8'hB2); load(8'h12, 8'hC3); load(8'h13, 8'hD4);
      load(8'hFE, 8'h5A); load(8'hFF, 8'h6B); load(8'h00, 8'h7C); load(8'h01, 8'h8D);
      rst = 1'b0;
      tick();
      chk("idle_after_reset", {12'd0, busy, done, mem_req, mem_write, mem_addr, mem_write_data}, 32'd0);

      // Table-driven copies with the grant held high.
      for (int i = 0; i < 4; i++) begin
         run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, 0, cyc);
         chk($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cyc);
         chk($sformatf("v%0d_dst_data", i), peek4(vecs[i].dst), vecs[i].exp_data);
         chk($sformatf("v%0d_writes", i), wr_total - wr_base, {24'd0, vecs[i].len});
         chk($sformatf("v%0d_req_cycles", i), req_total - req_base, 2 * vecs[i].len);
         chk($sformatf("v%0d_done_pulses", i), done_total - done_base, 32'd1);
         chk($sformatf("v%0d_reads", i), rd_total - rd_base, {24'd0, vecs[i].len});
         for (int j = 0; j < int'(vecs[i].len); j++)
            chk($sformatf("v%0d_rd_addr%0d", i, j), {24'd0, rd_log[8'(rd_base + j)]},
                {24'd0, vecs[i].src + 8'(j)});
      end
      chk("basic_src_unchanged", peek4(8'h10), 32'hA1B2C3D4);
      chk("wrap_src_unchanged", peek4(8'hFE), 32'h5A6B7C8D);

      // Grant stalls: 3 cycles in the first READ, 2 in the first WRITE.
      stall[1] = 1'b1; stall[2] = 1'b1; stall[3] = 1'b1;
      stall[5] = 1'b1; stall[6] = 1'b1;
      run_copy(8'h10, 8'hB0, 8'd2, 0, cyc);
      for (int k = 0; k < 64; k++) stall[k] = 1'b0;
      chk("stall_done_cycle", cyc, 32'd10);
      chk("stall_dst_data", peek4(8'hB0), 32'hA1B20000);
      chk("stall_writes", wr_total - wr_base, 32'd2);

      // Start while busy: second start with other operands is dropped.
      run_copy(8'h10, 8'hA0, 8'd3, 2, cyc);
      chk("busy_start_done_cycle", cyc, 32'd7);
      chk("busy_start_dst_data", peek4(8'hA0), 32'hA1B2C300);
      chk("busy_start_no_second", {24'd0, mem[8'hC0]}, 32'd0);
      tick(); tick(); tick();
      chk("busy_start_done_once", done_total - done_base, 32'd1);
      chk("busy_start_stays_idle", {31'd0, busy}, 32'd0);
      chk("busy_start_writes", wr_total - wr_base, 32'd3);

      // Reset asserted between edges in the WRITE cycle of the second byte.
      src_addr = 8'h10; dst_addr = 8'h60; length = 8'd4; start = 1'b1; mem_gnt = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("pre_reset_in_write", {31'd0, mem_write}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {12'd0, busy, done, mem_req, mem_write, mem_addr, mem_write_data}, 32'd0);
      tick();
      rst = 1'b0;
      chk("reset_byte2_not_written", {24'd0, mem[8'h61]}, 32'd0);
      chk("reset_byte1_retained", {24'd0, mem[8'h60]}, 32'hA1);
      tick();
      run_copy(8'h11, 8'h70, 8'd2, 0, cyc);
      chk("post_reset_done_cycle", cyc, 32'd5);
      chk("post_reset_dst_data", peek4(8'h70), 32'hB2C30000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
